// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: start control, instruction-memory read port, decoder issue port and status.
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    input  start, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr, opcode, pc, halted
  );

  modport slave (
    output start, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: fetches imem[pc], holds it for the decoder until accepted, then advances pc.
// HALT_DETECT_EN: when defined, an accepted all-zero word parks the unit in HALT until reset.
module instr_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [31:0]       r_instr;
  logic [31:0]       w_instr_nxt;
  logic              w_halt_word;

`ifdef HALT_DETECT_EN
  assign w_halt_word = (r_instr == 32'h0000_0000);
  assign bus.halted  = (r_state == S_HALT);
`else
  assign w_halt_word = 1'b0;
  assign bus.halted  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  // pc only moves on an accepted, non-halt handshake; wraps naturally at 2^ADDR_W.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_instr_nxt = bus.imem_rdata;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.instr_ready) begin
          if (w_halt_word) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt    = r_pc + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == S_ISSUE);
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[6:0];
  assign bus.pc          = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory latency, random decoder readiness, spurious acks and starts.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int ADDR_W = 8;
`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W)) u_if ();
  instr_fetch #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(u_if));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];
  int          delay_q [$];

  bit mem_auto, rdy_auto, spur_en, mon_en, tput_chk;
  int max_delay, ready_pct;
  logic        m_ack, m_ready, a_ack, a_ready;
  logic [31:0] m_data, a_data;

  assign u_if.imem_ack    = mem_auto ? a_ack  : m_ack;
  assign u_if.imem_rdata  = mem_auto ? a_data : m_data;
  assign u_if.instr_ready = rdy_auto ? a_ready : m_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: each request waits a chosen number of cycles before acking.
  initial begin
    bit in_req = 0;
    int wcnt = 0, cur_d = 0;
    a_ack = 1'b0;
    a_data = '0;
    forever begin
      @(posedge clk);
      #1;
      a_ack = 1'b0;
      if (u_if.imem_req) begin
        if (!in_req) begin
          in_req = 1;
          wcnt = 0;
          cur_d = (delay_q.size() != 0) ? delay_q.pop_front() : $urandom_range(0, max_delay);
        end
        if (wcnt >= cur_d) begin
          a_ack  = 1'b1;
          a_data = mem[u_if.imem_addr];
          in_req = 0;
        end else begin
          wcnt++;
        end
      end else begin
        in_req = 0;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          a_ack  = 1'b1;
          a_data = $urandom;
        end
      end
    end
  end

  // Decoder: accepts randomly while the scoreboard still expects instructions.
  initial begin
    a_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      a_ready = (exp_q.size() != 0) && ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor + reference model: pc advances per accepted non-halt instruction,
  // an instruction is presented the cycle after its ack and withdrawn after acceptance.
  initial begin
    logic [ADDR_W-1:0] m_pc;
    bit m_valid, m_halted, prev_ack, prev_hs, prev_halt;
    int last_hs;
    logic [31:0] w;
    m_pc = '0; m_valid = 0; m_halted = 0; prev_ack = 0; prev_hs = 0; prev_halt = 0; last_hs = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pc = '0; m_valid = 0; m_halted = 0; prev_ack = 0; prev_hs = 0; prev_halt = 0; last_hs = -1;
        exp_q.delete();
      end else if (mon_en) begin
        if (prev_ack) m_valid = 1;
        if (prev_hs) begin
          m_valid = 0;
          if (prev_halt) m_halted = 1;
          else m_pc = m_pc + 1'b1;
        end
        check("instr_valid", 32'(u_if.instr_valid), 32'(m_valid));
        check("pc", 32'(u_if.pc), 32'(m_pc));
        check("halted", 32'(u_if.halted), 32'(m_halted));
        if (u_if.imem_req) check("imem_addr", 32'(u_if.imem_addr), 32'(m_pc));
        if (u_if.instr_valid || u_if.halted) check("no_req_when_held", 32'(u_if.imem_req), 32'd0);
        if (u_if.instr_valid && exp_q.size() != 0) begin
          check("instr", u_if.instr, exp_q[0]);
          check("opcode", 32'(u_if.opcode), 32'(exp_q[0][6:0]));
        end
        prev_ack  = u_if.imem_req && u_if.imem_ack;
        prev_hs   = u_if.instr_valid && u_if.instr_ready;
        prev_halt = 0;
        if (prev_hs) begin
          check("hs_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            prev_halt = HALT_EN && (w == 32'h0);
            if (tput_chk) begin
              if (last_hs >= 0) check("throughput_gap", 32'(cyc - last_hs), 32'd2);
              last_hs = cyc;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 u_if.start = 1'b1;
    @(posedge clk);
    #1 u_if.start = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < limit) begin
      @(posedge clk);
      #1 u_if.start = ($urandom_range(0, 7) == 0);
      c++;
    end
    u_if.start = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d instructions still pending after %0d cycles, required 0", name, exp_q.size(), c);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
  endtask

  initial begin
    rst = 1'b1; u_if.start = 1'b0;
    mem_auto = 1; rdy_auto = 1; spur_en = 0; mon_en = 1; tput_chk = 0;
    max_delay = 3; ready_pct = 50;
    m_ack = 1'b0; m_ready = 1'b0; m_data = '0;
    fill_mem();
    mem[0] = 32'h00A0_0093;
    mem[3] = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_imem_req", 32'(u_if.imem_req), 32'd0);
    check("rst_instr_valid", 32'(u_if.instr_valid), 32'd0);
    check("rst_pc", 32'(u_if.pc), 32'd0);
    check("rst_instr", u_if.instr, 32'd0);
    check("rst_halted", 32'(u_if.halted), 32'd0);

    // Phase 1: first ack after 1 wait cycle, second after 5; zero word at pc 3.
    delay_q.push_back(1);
    delay_q.push_back(5);
    spur_en = 1;
    for (int k = 0; k < (HALT_EN ? 4 : 20); k++) exp_q.push_back(mem[k]);
    pulse_start();
    wait_drain(4000, "phase1_drain");
    repeat (4) @(posedge clk);
    pulse_start();
    repeat (4) @(posedge clk);
    @(negedge clk);
`ifdef HALT_DETECT_EN
    check("halt_halted", 32'(u_if.halted), 32'd1);
    check("halt_pc", 32'(u_if.pc), 32'd3);
    check("halt_imem_req", 32'(u_if.imem_req), 32'd0);
    check("halt_instr_valid", 32'(u_if.instr_valid), 32'd0);
`else
    check("nohalt_pc", 32'(u_if.pc), 32'd20);
    check("nohalt_halted", 32'(u_if.halted), 32'd0);
`endif

    // Phase 2: directed reset interactions with manually driven ack/ready.
    mon_en = 0; mem_auto = 0; rdy_auto = 0;
    do_reset();
    pulse_start();
    @(negedge clk);
    check("fetch_req", 32'(u_if.imem_req), 32'd1);
    check("fetch_addr", 32'(u_if.imem_addr), 32'd0);
    @(posedge clk);
    #1 m_ack = 1'b1; m_data = 32'hDEAD_BEEF; rst = 1'b1;
    @(posedge clk);
    #1 m_ack = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_ack_valid", 32'(u_if.instr_valid), 32'd0);
    check("rst_ack_instr", u_if.instr, 32'd0);
    check("rst_ack_pc", 32'(u_if.pc), 32'd0);
    check("rst_ack_req", 32'(u_if.imem_req), 32'd0);
    @(posedge clk);
    #1 m_ack = 1'b1; m_data = 32'h1234_5678; m_ready = 1'b1;
    @(posedge clk);
    #1 m_ack = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("idle_ack_valid", 32'(u_if.instr_valid), 32'd0);
    check("idle_ack_instr", u_if.instr, 32'd0);
    check("idle_ack_req", 32'(u_if.imem_req), 32'd0);
    pulse_start();
    m_ack = 1'b1; m_data = 32'hCAFE_0013;
    @(posedge clk);
    #1 m_ack = 1'b0;
    @(negedge clk);
    check("issue_valid", 32'(u_if.instr_valid), 32'd1);
    check("issue_instr", u_if.instr, 32'hCAFE_0013);
    check("issue_opcode", 32'(u_if.opcode), 32'h13);
    @(posedge clk);
    #1 m_ready = 1'b1; rst = 1'b1; u_if.start = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0; rst = 1'b0; u_if.start = 1'b0;
    @(negedge clk);
    check("rst_issue_valid", 32'(u_if.instr_valid), 32'd0);
    check("rst_issue_instr", u_if.instr, 32'd0);
    check("rst_issue_pc", 32'(u_if.pc), 32'd0);
    check("rst_prio_req", 32'(u_if.imem_req), 32'd0);

    // Phase 3: zero-wait memory, ready always high, pc wraps past 8'hFF.
    mem[3] = $urandom | 32'h1;
    mem_auto = 1; rdy_auto = 1; mon_en = 1;
    max_delay = 0; ready_pct = 100;
    delay_q.delete();
    do_reset();
    for (int k = 0; k < 258; k++) exp_q.push_back(mem[k % 256]);
    tput_chk = 1;
    pulse_start();
    wait_drain(3000, "wrap_drain");
    tput_chk = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap_pc", 32'(u_if.pc), 32'd2);

    // Phase 4: long memory latency and a hesitant decoder.
    fill_mem();
    max_delay = 6; ready_pct = 30;
    do_reset();
    for (int k = 0; k < 40; k++) exp_q.push_back(mem[k]);
    pulse_start();
    wait_drain(6000, "random_drain");
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8: width of the program counter and the instruction-memory word address.
REQ-002 SHALL provide port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1: one-cycle pulse that begins fetching from the current pc; honoured only in IDLE.
REQ-005 SHALL provide port imem_req  output  1: read request to instruction memory.
REQ-006 SHALL provide port imem_addr  output  ADDR_W: word address of the request; equals pc.
REQ-007 SHALL provide port imem_ack  input  1: read data valid; sampled only while imem_req=1.
REQ-008 SHALL provide port imem_rdata  input  32: instruction word; valid when imem_ack=1.
REQ-009 SHALL provide port instr_valid  output  1: instr/opcode hold a fetched instruction for the decoder.
REQ-010 SHALL provide port instr_ready  input  1: decoder accepts the instruction.
REQ-011 SHALL provide port instr  output  32: registered instruction word.
REQ-012 SHALL provide port opcode  output  7: instr[6:0], the field the control unit decodes.
REQ-013 SHALL provide port pc  output  ADDR_W: address of the instruction held or being fetched.
REQ-014 SHALL provide port halted  output  1: fetch stopped on a halt word.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, ISSUE and HALT.
REQ-016 IDLE: imem_req=0, instr_valid=0; start=1 moves to FETCH on the next edge.
REQ-017 FETCH: imem_req=1 and imem_addr=pc, held until imem_ack=1; there is no timeout, so the unit waits any number of cycles.
REQ-018 On imem_ack=1 in FETCH: capture imem_rdata into instr, move to ISSUE, and drop imem_req; ack in cycle n gives instr_valid=1 in cycle n+1.
REQ-019 ISSUE: instr_valid=1; instr, opcode and pc stay stable until the handshake.
REQ-020 Handshake: instr_valid=1 and instr_ready=1 in the same cycle sets pc <= pc+1 and moves to FETCH; that edge clears instr_valid.
REQ-021 instr_ready while instr_valid=0 SHALL have no effect.
REQ-022 imem_ack outside FETCH SHALL be ignored.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 pc increments modulo 2^ADDR_W: pc = all-ones followed by an accepted handshake gives pc = 0.
REQ-025 Minimum throughput with zero-wait memory and instr_ready tied high: one instruction per 2 cycles.
REQ-026 HALT: imem_req=0, instr_valid=0, halted=1; HALT is left only by rst.

Reset
REQ-027 rst=1 at a rising edge SHALL set state=IDLE, pc=0, instr=0, instr_valid=0, imem_req=0 and halted=0, regardless of state.
REQ-028 Reset mid-FETCH SHALL drop imem_req in the cycle after the edge and discard any later ack from that request.
REQ-029 Reset mid-ISSUE SHALL discard the held instruction; pc returns to 0.
REQ-030 rst SHALL take priority over start, imem_ack and instr_ready in the same cycle.

Configuration
REQ-031 Macro HALT_DETECT_EN SHALL control halt-word detection.
REQ-032 With HALT_DETECT_EN defined: on handshake of an instruction equal to 32'h0000_0000, go to HALT instead of FETCH.
  - pc does not increment on that handshake.
  - The halt word is itself presented and accepted once.
REQ-033 Without HALT_DETECT_EN: a zero word is issued like any other instruction, HALT is unreachable, and halted is tied 0.

Verification
REQ-034 Reset, then pulse start, memory acks 1 cycle after req with 0x00A00093 -> imem_addr=0; instr_valid rises the cycle after ack; opcode=7'h13; after ready, pc=1 and imem_req=1.
REQ-035 Ack delayed 5 cycles -> imem_req stays 1 and imem_addr stable for all 5 cycles; instr_valid stays 0 until the cycle after ack.
REQ-036 instr_ready held 0 for 4 cycles in ISSUE -> instr, opcode and pc unchanged, no new imem_req; ready=1 -> pc increments by exactly 1.
REQ-037 ADDR_W=8, pc=8'hFF, handshake -> pc=8'h00 and imem_addr=8'h00 on the next fetch.
REQ-038 rst asserted in the cycle imem_ack=1 arrives -> next cycle state IDLE, instr=0, instr_valid=0, pc=0.
REQ-039 HALT_DETECT_EN defined, memory returns 0x00000000 at pc=3 -> word accepted once, then halted=1, imem_req=0 and pc=3 held; start ignored. Without the macro -> fetch continues to pc=4.
